// File: rtl/spi_pkg.sv
// spi_pkg: SPI mode encodings, slave state enum and edge-role helper
package spi_pkg;
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;
    // modes 0 and 3 sample mosi on the rising sck edge, modes 1 and 2 on the falling one
    function automatic logic sample_on_rise(input spi_mode_e m);
        return (m == MODE0) || (m == MODE3);
    endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: N-stage synchroniser with one extra registered copy for change detection
module spi_sync #(
    parameter int N       = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic chg_o
);
    logic [N:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) sync_q <= {(N+1){RST_VAL}};
        else     sync_q <= {sync_q[N-1:0], d_i};
    end
    // rise = chg_o & q_o, fall = chg_o & ~q_o
    assign q_o   = sync_q[N-1];
    assign chg_o = sync_q[N-1] ^ sync_q[N];
endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave with TX holding register, RX strobe and error flags
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              tx_underrun
);
    localparam int        CW        = $clog2(DATA_W);
    localparam spi_mode_e MODE      = spi_mode_e'({CPOL, CPHA});
    localparam logic      SAMPLE_HI = sample_on_rise(MODE);

    function automatic logic out_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    logic sck_s, sck_chg, cs_s, cs_chg, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_q;
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, hold_q, hold_d;
    logic hold_full_q, hold_full_d, miso_q, miso_d;
    logic rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, underrun_q, underrun_d;
    logic run, sample, shift, last, load, wr;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(CPOL)) u_sck (
        .clk(clk), .rst(rst), .d_i(sck), .q_o(sck_s), .chg_o(sck_chg)
    );
    // cs resets low so a master already holding cs low at reset release is not seen as a new fall
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
        .clk(clk), .rst(rst), .d_i(cs), .q_o(cs_s), .chg_o(cs_chg)
    );

    always_ff @(posedge clk) begin
        if (rst) mosi_q <= '0;
        else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    always_comb begin
        run         = (state_q == ACTIVE) && !cs_chg;
        sample      = run && sck_chg && (sck_s == SAMPLE_HI);
        // with CPHA=0 the trailing edge right after a word boundary must keep the freshly loaded MSB
        shift       = run && sck_chg && (sck_s != SAMPLE_HI) && (CPHA || cnt_q != '0);
        last        = cnt_q == CW'(DATA_W - 1);
        load        = ((state_q == IDLE) && cs_chg && !cs_s) || (sample && last);
        wr          = tx_valid && !hold_full_q;
        state_d     = (state_q == IDLE) ? ((cs_chg && !cs_s) ? ACTIVE : IDLE)
                                        : ((cs_chg && cs_s) ? IDLE : ACTIVE);
        frame_err_d = (state_q == ACTIVE) && cs_chg && cs_s && (cnt_q != '0);
        cnt_d       = (state_d == IDLE) ? '0 : sample ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        rx_sh_d     = !sample ? rx_sh_q : MSB_FIRST ? {rx_sh_q[DATA_W-2:0], mosi_s}
                                                    : {mosi_s, rx_sh_q[DATA_W-1:1]};
        rx_valid_d  = sample && last;
        rx_data_d   = rx_valid_d ? rx_sh_d : rx_data_q;
        underrun_d  = load && !hold_full_q;
        tx_sh_d     = load ? (hold_full_q ? hold_q : '0)
                    : !shift ? tx_sh_q
                    : MSB_FIRST ? {tx_sh_q[DATA_W-2:0], 1'b0} : {1'b0, tx_sh_q[DATA_W-1:1]};
        hold_d      = wr ? tx_data : hold_q;
        hold_full_d = wr || (hold_full_q && !load);
        miso_d      = (state_d == IDLE) ? 1'b0
                    : CPHA ? (shift ? out_bit(tx_sh_q) : miso_q) : out_bit(tx_sh_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            underrun_q  <= underrun_d;
        end
    end

    assign miso        = miso_q;
    assign tx_ready    = !hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: directed bench for a mode-0 8-bit MSB-first slave and a mode-3 16-bit LSB-first slave
module tb_spi_slave_param;
    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst, sck, mosi, cs_a, cs_b, sel;
    logic miso_a, miso_b, tx_valid_a, tx_valid_b, tx_ready_a, tx_ready_b;
    logic rx_valid_a, rx_valid_b, frame_err_a, frame_err_b, und_a, und_b;
    logic [7:0]  tx_data_a, rx_data_a;
    logic [15:0] tx_data_b, rx_data_b;
    int n_chk = 0, n_pass = 0;
    int n_rxv_a = 0, n_rxv_b = 0, n_fe_a = 0, n_und_a = 0;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs_a), .mosi(mosi), .miso(miso_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .frame_err(frame_err_a), .tx_underrun(und_a)
    );

    spi_slave_param #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs_b), .mosi(mosi), .miso(miso_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .frame_err(frame_err_b), .tx_underrun(und_b)
    );

    always @(negedge clk) begin
        n_rxv_a += int'(rx_valid_a);
        n_rxv_b += int'(rx_valid_b);
        n_fe_a  += int'(frame_err_a);
        n_und_a += int'(und_a);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tx_wr(input bit b, input logic [15:0] d);
        @(negedge clk);
        if (b) begin tx_data_b = d; tx_valid_b = 1'b1; end
        else begin tx_data_a = d[7:0]; tx_valid_a = 1'b1; end
        @(negedge clk);
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
    endtask

    task automatic cs_dn();
        sck = sel;
        #HALF;
        if (sel) cs_b = 1'b0; else cs_a = 1'b0;
        #HALF;
    endtask

    task automatic cs_up();
        #HALF;
        cs_a = 1'b1;
        cs_b = 1'b1;
        #(2*HALF);
    endtask

    // sel=0: mode 0 MSB-first master; sel=1: mode 3 LSB-first master
    task automatic spi_word(input int w, input int nb, input logic [31:0] tx, output logic [31:0] rx);
        rx = '0;
        for (int i = 0; i < nb; i++) begin
            int idx;
            idx = sel ? i : w - 1 - i;
            if (!sel) begin
                mosi = tx[idx];
                #HALF;
                sck = 1'b1;
                rx[idx] = miso_a;
                #HALF;
                sck = 1'b0;
            end else begin
                sck = 1'b0;
                mosi = tx[idx];
                #HALF;
                sck = 1'b1;
                rx[idx] = miso_b;
                #HALF;
            end
        end
    endtask

    initial begin
        logic [31:0] r1, r2;
        int v0, f0, u0;
        rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs_a = 1'b1; cs_b = 1'b1; sel = 1'b0;
        tx_valid_a = 1'b0; tx_valid_b = 1'b0; tx_data_a = '0; tx_data_b = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset miso", miso_a, 0);
        chk("reset tx_ready", tx_ready_a, 1);
        chk("reset rx_data", rx_data_a, 0);
        chk("reset rx_valid", rx_valid_a, 0);
        chk("reset frame_err", frame_err_a, 0);
        chk("reset tx_underrun", und_a, 0);

        // mode 0 single word
        tx_wr(0, 16'h3C);
        chk("ready after write", tx_ready_a, 0);
        v0 = n_rxv_a;
        cs_dn();
        spi_word(8, 8, 32'hA5, r1);
        cs_up();
        chk("m0 rx_data", rx_data_a, 32'hA5);
        chk("m0 rx_valid count", v0 == n_rxv_a - 1, 1);
        chk("m0 master rx", r1, 32'h3C);
        chk("m0 tx_ready", tx_ready_a, 1);
        chk("m0 miso idle", miso_a, 0);

        // continuous transfer, holding register never empty at a load
        tx_wr(0, 16'h99);
        v0 = n_rxv_a; u0 = n_und_a;
        cs_dn();
        fork
            spi_word(8, 8, 32'h11, r1);
            begin #(4*HALF); tx_wr(0, 16'h66); end
        join
        chk("cont word1 rx_data", rx_data_a, 32'h11);
        fork
            spi_word(8, 8, 32'h22, r2);
            begin #(4*HALF); tx_wr(0, 16'h5A); end
        join
        cs_up();
        chk("cont master rx1", r1, 32'h99);
        chk("cont master rx2", r2, 32'h66);
        chk("cont rx_valid count", n_rxv_a - v0, 2);
        chk("cont underrun count", n_und_a - u0, 0);
        chk("cont rx_data", rx_data_a, 32'h22);

        // abort after 3 bits
        v0 = n_rxv_a; f0 = n_fe_a;
        cs_dn();
        spi_word(8, 3, 32'hFF, r1);
        cs_up();
        chk("abort frame_err count", n_fe_a - f0, 1);
        chk("abort rx_data held", rx_data_a, 32'h22);
        chk("abort rx_valid count", n_rxv_a - v0, 0);
        f0 = n_fe_a;
        cs_dn();
        spi_word(8, 8, 32'h81, r1);
        cs_up();
        chk("after abort rx_data", rx_data_a, 32'h81);
        chk("full frame no frame_err", n_fe_a - f0, 0);

        // underrun at frame start
        u0 = n_und_a;
        cs_dn();
        chk("underrun at start", n_und_a - u0, 1);
        fork
            spi_word(8, 8, 32'h5A, r1);
            begin #(4*HALF); tx_wr(0, 16'h77); end
        join
        cs_up();
        chk("underrun master rx", r1, 32'h00);
        chk("underrun count", n_und_a - u0, 1);

        // mode 3, 16-bit, LSB first
        sel = 1'b1;
        tx_wr(1, 16'h1234);
        v0 = n_rxv_b;
        cs_dn();
        spi_word(16, 16, 32'hBEEF, r1);
        cs_up();
        chk("m3 rx_data", rx_data_b, 32'hBEEF);
        chk("m3 master rx", r1, 32'h1234);
        chk("m3 rx_valid count", n_rxv_b - v0, 1);

        // reset mid-transfer
        sel = 1'b0;
        tx_wr(0, 16'hFF);
        cs_dn();
        fork
            spi_word(8, 4, 32'hC3, r1);
            begin #HALF; tx_wr(0, 16'h00); end
        join
        #HALF;
        chk("pre-rst miso", miso_a, 1);
        chk("pre-rst tx_ready", tx_ready_a, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst miso", miso_a, 0);
        chk("rst tx_ready", tx_ready_a, 1);
        chk("rst rx_data", rx_data_a, 0);
        chk("rst rx_valid", rx_valid_a, 0);
        chk("rst frame_err", frame_err_a, 0);
        chk("rst tx_underrun", und_a, 0);
        @(negedge clk);
        rst = 1'b0;
        f0 = n_fe_a;
        cs_up();
        chk("rst no frame_err", n_fe_a - f0, 0);
        tx_wr(0, 16'h3C);
        v0 = n_rxv_a;
        cs_dn();
        spi_word(8, 8, 32'hC3, r1);
        cs_up();
        chk("post-rst rx_data", rx_data_a, 32'hC3);
        chk("post-rst rx_valid count", n_rxv_a - v0, 1);
        chk("post-rst master rx", r1, 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
